mnist_argmax_seq: RTL and testbench
===================================

Name: mnist_argmax_seq

Overview:
- Hardware consumer of the inference core's result interface: the 10×16-bit `digit_scores` bus plus `done`.
- Replaces testbench-side argmax. On each rising edge of `done` it snapshots all class scores, then scans them one per cycle.
- Presents the winning digit index and its score on a valid/ready output port, for a UART/LED reporter or a system bus.

Parameters:
- NUM_CLASSES, 10, number of class scores on the input bus.
- SCORE_W, 16, width of one score.
- IDX_W, 4, width of the predicted index; must satisfy 2**IDX_W >= NUM_CLASSES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- done_in  in  1  `done` from the inference core; level, may stay high.
- digit_scores  in  NUM_CLASSES*SCORE_W  class i occupies bits [i*SCORE_W +: SCORE_W].
- pred_valid  out  1  result available.
- pred_ready  in  1  downstream accepts the result.
- pred_digit  out  IDX_W  argmax index.
- pred_score  out  SCORE_W  score of the winning class.
- busy  out  1  high in SCAN state.
- overrun  out  1  sticky: a new result arrived while the block was not IDLE.

Behaviour:
- Reset values: all outputs 0; done_q=0; state=IDLE; shadow score registers 0.
- done_q is a registered copy of done_in. A rising edge is done_in=1 && done_q=0.
  - done_in held high across reset release therefore counts as a rising edge. This is intended.
- State IDLE:
  - On a rising edge, latch the whole `digit_scores` into the shadow registers.
  - Set idx=0, max=0, arg=0, then go to SCAN.
  - Otherwise stay in IDLE.
- State SCAN: one class per clock.
  - If shadow[idx] >= max (unsigned), set max=shadow[idx] and arg=idx.
  - >= is required, so ties resolve to the highest index.
  - When idx==NUM_CLASSES-1, go to VALID and register pred_digit, pred_score and pred_valid=1 on the same edge (the update for the last index is included). Otherwise idx=idx+1.
- State VALID:
  - pred_valid=1; pred_digit and pred_score are held stable until the handshake.
  - On an edge with pred_ready=1: pred_valid=0, go to IDLE. pred_digit and pred_score keep their last value.
  - pred_ready is ignored outside VALID.
- Latency: capture on edge 0, scan on edges 1..NUM_CLASSES. pred_valid is visible after edge NUM_CLASSES, i.e. 10 cycles after the capture edge.
  - Minimum spacing between accepted results is NUM_CLASSES+2 cycles when pred_ready is held at 1.
- busy=1 exactly while state==SCAN.
- Rising edge of done_in in SCAN or VALID:
  - Ignored for data; the current result is unaffected.
  - overrun is set to 1 and is cleared only by rst.
- Rising edge in the same cycle as the VALID→IDLE handshake: treated as arriving in VALID, so it is dropped and overrun is set.
- Changes on digit_scores after the capture edge have no effect.
- rst asserted mid-SCAN or mid-VALID: asynchronous return to reset values; any partial result is discarded.

Optional Feature:
- Macro: ARGMAX_SIGNED_CMP_EN.
- Defined: scores are two's-complement and the comparison is signed. max initialises to the most negative value (0x8000 at SCORE_W=16).
- Undefined: unsigned comparison, max initialises to 0.
- Tie rule (highest index wins) and timing are identical in both builds.

Decomposition:
- Shared package mnist_pkg:
  - NUM_CLASSES, SCORE_W, IDX_W constants.
  - Typedef score_t as logic [SCORE_W-1:0].
  - Typedef idx_t.
  - State enum argmax_state_t {IDLE, SCAN, VALID}.
- No sub-module needed. The compare/update is one registered stage inside the module, with the signed/unsigned compare selected by the macro.

Test Plan:
- Scores: class 7=0x1234, all others 0x0100. Pulse done_in → pred_valid 10 cycles after the capture edge, pred_digit=7, pred_score=0x1234, busy high for exactly 10 cycles.
- All scores 0x0100 → pred_digit=9, pred_score=0x0100. All zero → pred_digit=9, pred_score=0x0000.
- Class 3=0x8000, others 0x7FFF.
  - Unsigned build → digit 3, score 0x8000.
  - ARGMAX_SIGNED_CMP_EN build → digit 9, score 0x7FFF.
- Backpressure: pred_ready=0 for 20 cycles after valid → digit, score and valid stable throughout. Then pred_ready=1 for one cycle → pred_valid=0 on the next edge, state IDLE.
- Overrun: with class 2 the winner, pulse done_in again at scan cycle 4 and change digit_scores → result still digit 2, overrun=1 and remains 1 after the handshake until rst.
- Assert rst at scan cycle 5, release, keep done_in low → pred_valid=0, busy=0, overrun=0. Then a new done pulse yields a correct fresh result.

Source files
------------

// File: rtl/mnist_pkg.sv
// -----------------------------------------------------------------------------
// mnist_pkg
// Shared constants and types for the MNIST inference result path.
//   NUM_CLASSES : number of class scores on the result bus
//   SCORE_W     : width of one class score
//   IDX_W       : width of a class index (2**IDX_W >= NUM_CLASSES)
//   score_t, idx_t, argmax_state_t
// -----------------------------------------------------------------------------
package mnist_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int SCORE_W     = 16;
  localparam int IDX_W       = 4;

  typedef logic [SCORE_W-1:0] score_t;
  typedef logic [IDX_W-1:0]   idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    VALID = 2'd2
  } argmax_state_t;

endpackage

// File: rtl/mnist_argmax_seq_if.sv
// -----------------------------------------------------------------------------
// mnist_argmax_seq_if
// Prediction output port of mnist_argmax_seq.
//   pred_valid : result available
//   pred_ready : consumer accepts the result
//   pred_digit : argmax class index
//   pred_score : score of the winning class
// Handshake: a result transfers on a rising clk edge where pred_valid and
// pred_ready are both 1. While pred_valid is 1 and no transfer has happened,
// pred_digit and pred_score are held stable. pred_ready may be driven freely
// and has no effect while pred_valid is 0.
// Modports: master = producer (the argmax block), slave = consumer.
// -----------------------------------------------------------------------------
interface mnist_argmax_seq_if;
  import mnist_pkg::*;

  logic   pred_valid;
  logic   pred_ready;
  idx_t   pred_digit;
  score_t pred_score;

  modport master (
    output pred_valid,
    output pred_digit,
    output pred_score,
    input  pred_ready
  );

  modport slave (
    input  pred_valid,
    input  pred_digit,
    input  pred_score,
    output pred_ready
  );

endinterface

// File: rtl/mnist_argmax_seq.sv
// -----------------------------------------------------------------------------
// mnist_argmax_seq
// Argmax over the inference core's class scores. On a rising edge of done_in
// the whole score bus is snapshotted, then one class is compared per clock;
// the winning index and score are offered on a valid/ready port.
//
// Ports:
//   clk          : system clock, rising edge
//   rst          : asynchronous active-high reset
//   done_in      : level 'done' from the inference core (edge detected here)
//   digit_scores : class i at [i*SCORE_W +: SCORE_W]
//   pred         : mnist_argmax_seq_if.master (pred_valid/ready/digit/score)
//   busy         : 1 while scanning
//   overrun      : sticky, a new result arrived while not IDLE (rst clears)
//   dbg_state    : current FSM state
//
// Build option: define ARGMAX_SIGNED_CMP_EN to treat scores as two's
// complement (signed compare, running max starts at the most negative value).
// Default is unsigned compare with the running max starting at 0.
// Ties always resolve to the highest index because the compare is >=.
// -----------------------------------------------------------------------------
module mnist_argmax_seq
  import mnist_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           done_in,
  input  logic [NUM_CLASSES*SCORE_W-1:0] digit_scores,
  mnist_argmax_seq_if.master             pred,
  output logic                           busy,
  output logic                           overrun,
  output argmax_state_t                  dbg_state
);

`ifdef ARGMAX_SIGNED_CMP_EN
  localparam score_t MAX_INIT = {1'b1, {(SCORE_W-1){1'b0}}};
`else
  localparam score_t MAX_INIT = '0;
`endif

  localparam idx_t LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  argmax_state_t r_state;
  argmax_state_t w_state_nxt;

  logic   r_done_q;
  score_t r_shadow [NUM_CLASSES];
  idx_t   r_idx;
  score_t r_max;
  idx_t   r_arg;
  logic   r_pred_valid;
  idx_t   r_pred_digit;
  score_t r_pred_score;
  logic   r_overrun;

  logic   w_rise;
  logic   w_last;
  score_t w_cur;
  logic   w_take;
  score_t w_new_max;
  idx_t   w_new_arg;

  assign w_rise = done_in & ~r_done_q;
  assign w_last = (r_idx == LAST_IDX);
  assign w_cur  = r_shadow[r_idx];

`ifdef ARGMAX_SIGNED_CMP_EN
  assign w_take = ($signed(w_cur) >= $signed(r_max));
`else
  assign w_take = (w_cur >= r_max);
`endif

  // Result of the compare for the class at r_idx; on the last index this is
  // also the final answer registered into the output port.
  assign w_new_max = w_take ? w_cur : r_max;
  assign w_new_arg = w_take ? r_idx : r_arg;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_rise)          w_state_nxt = SCAN;
      SCAN:    if (w_last)          w_state_nxt = VALID;
      VALID:   if (pred.pred_ready) w_state_nxt = IDLE;
      default:                      w_state_nxt = IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done_q     <= 1'b0;
      r_idx        <= '0;
      r_max        <= '0;
      r_arg        <= '0;
      r_pred_valid <= 1'b0;
      r_pred_digit <= '0;
      r_pred_score <= '0;
      r_overrun    <= 1'b0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        r_shadow[i] <= '0;
      end
    end else begin
      r_done_q <= done_in;

      // A new result while scanning or presenting is dropped; this includes
      // the cycle of the VALID->IDLE handshake.
      if (w_rise && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_rise) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
              r_shadow[i] <= digit_scores[i*SCORE_W +: SCORE_W];
            end
            r_idx <= '0;
            r_max <= MAX_INIT;
            r_arg <= '0;
          end
        end
        SCAN: begin
          r_max <= w_new_max;
          r_arg <= w_new_arg;
          if (w_last) begin
            r_pred_digit <= w_new_arg;
            r_pred_score <= w_new_max;
            r_pred_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        VALID: begin
          if (pred.pred_ready) begin
            r_pred_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign pred.pred_valid = r_pred_valid;
  assign pred.pred_digit = r_pred_digit;
  assign pred.pred_score = r_pred_score;
  assign busy            = (r_state == SCAN);
  assign overrun         = r_overrun;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_mnist_argmax_seq.sv
// -----------------------------------------------------------------------------
// tb_mnist_argmax_seq
// Directed bench for mnist_argmax_seq. Inputs change 1 time unit after a
// rising clk edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_mnist_argmax_seq;
  import mnist_pkg::*;

  logic                           clk;
  logic                           rst;
  logic                           done_in;
  logic [NUM_CLASSES*SCORE_W-1:0] digit_scores;
  logic                           busy;
  logic                           overrun;
  argmax_state_t                  dbg_state;

  mnist_argmax_seq_if pif();

  mnist_argmax_seq dut (
    .clk          (clk),
    .rst          (rst),
    .done_in      (done_in),
    .digit_scores (digit_scores),
    .pred         (pif.master),
    .busy         (busy),
    .overrun      (overrun),
    .dbg_state    (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  score_t sc [NUM_CLASSES];

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_scores();
    for (int i = 0; i < NUM_CLASSES; i++) begin
      digit_scores[i*SCORE_W +: SCORE_W] = sc[i];
    end
  endtask

  task automatic set_all(input score_t v);
    for (int i = 0; i < NUM_CLASSES; i++) sc[i] = v;
    apply_scores();
  endtask

  // Raise done_in for one edge; returns just after the capture edge.
  task automatic start_capture();
    done_in = 1'b1;
    cyc();
    done_in = 1'b0;
  endtask

  // Wait (bounded) for pred_valid; lat = edges waited, bcnt = cycles busy was 1.
  task automatic wait_valid(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!pif.pred_valid && lat < 40) begin
      if (busy) bcnt++;
      cyc();
      lat++;
    end
  endtask

  task automatic handshake();
    pif.pred_ready = 1'b1;
    cyc();
    pif.pred_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    done_in = 1'b0;
    pif.pred_ready = 1'b0;
    set_all(16'h0000);
    cyc(); cyc();
    checks++; if (pif.pred_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", pif.pred_valid); end
    checks++; if (pif.pred_digit !== 4'd0) begin failures++; $display("FAIL reset_digit got=%0d exp=0", pif.pred_digit); end
    checks++; if (pif.pred_score !== 16'h0000) begin failures++; $display("FAIL reset_score got=%h exp=0000", pif.pred_score); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
    rst = 1'b0;
    cyc(); cyc();
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL idle_no_done got=%0d exp=%0d", dbg_state, IDLE); end
  endtask

  task automatic test_basic();
    int lat, bcnt;
    set_all(16'h0100);
    sc[7] = 16'h1234;
    apply_scores();
    start_capture();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_start got=%b exp=1", busy); end
    wait_valid(lat, bcnt);
    checks++; if (lat !== 10) begin failures++; $display("FAIL basic_latency got=%0d exp=10", lat); end
    checks++; if (bcnt !== 10) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=10", bcnt); end
    checks++; if (pif.pred_digit !== 4'd7) begin failures++; $display("FAIL basic_digit got=%0d exp=7", pif.pred_digit); end
    checks++; if (pif.pred_score !== 16'h1234) begin failures++; $display("FAIL basic_score got=%h exp=1234", pif.pred_score); end
    checks++; if (dbg_state !== VALID) begin failures++; $display("FAIL basic_state got=%0d exp=%0d", dbg_state, VALID); end
    handshake();
    checks++; if (pif.pred_valid !== 1'b0) begin failures++; $display("FAIL basic_accept_valid got=%b exp=0", pif.pred_valid); end
    checks++; if (pif.pred_digit !== 4'd7) begin failures++; $display("FAIL basic_digit_hold got=%0d exp=7", pif.pred_digit); end
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL basic_accept_state got=%0d exp=%0d", dbg_state, IDLE); end
  endtask

  task automatic test_ties();
    int lat, bcnt;
    set_all(16'h0100);
    start_capture();
    wait_valid(lat, bcnt);
    checks++; if (pif.pred_digit !== 4'd9) begin failures++; $display("FAIL tie_equal_digit got=%0d exp=9", pif.pred_digit); end
    checks++; if (pif.pred_score !== 16'h0100) begin failures++; $display("FAIL tie_equal_score got=%h exp=0100", pif.pred_score); end
    handshake();
    set_all(16'h0000);
    start_capture();
    wait_valid(lat, bcnt);
    checks++; if (pif.pred_digit !== 4'd9) begin failures++; $display("FAIL tie_zero_digit got=%0d exp=9", pif.pred_digit); end
    checks++; if (pif.pred_score !== 16'h0000) begin failures++; $display("FAIL tie_zero_score got=%h exp=0000", pif.pred_score); end
    handshake();
  endtask

  task automatic test_msb();
    int lat, bcnt;
    idx_t   exp_d;
    score_t exp_s;
`ifdef ARGMAX_SIGNED_CMP_EN
    exp_d = 4'd9; exp_s = 16'h7FFF;
`else
    exp_d = 4'd3; exp_s = 16'h8000;
`endif
    set_all(16'h7FFF);
    sc[3] = 16'h8000;
    apply_scores();
    start_capture();
    wait_valid(lat, bcnt);
    checks++; if (pif.pred_digit !== exp_d) begin failures++; $display("FAIL msb_digit got=%0d exp=%0d", pif.pred_digit, exp_d); end
    checks++; if (pif.pred_score !== exp_s) begin failures++; $display("FAIL msb_score got=%h exp=%h", pif.pred_score, exp_s); end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat, bcnt, bad;
    set_all(16'h0010);
    sc[5] = 16'h0042;
    apply_scores();
    start_capture();
    wait_valid(lat, bcnt);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (pif.pred_valid !== 1'b1 || pif.pred_digit !== 4'd5 || pif.pred_score !== 16'h0042) begin
        bad++;
        $display("FAIL bp_hold cycle=%0d got=%b/%0d/%h exp=1/5/0042", k, pif.pred_valid, pif.pred_digit, pif.pred_score);
      end
      cyc();
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL bp_hold_total got=%0d exp=0", bad); end
    handshake();
    checks++; if (pif.pred_valid !== 1'b0) begin failures++; $display("FAIL bp_accept_valid got=%b exp=0", pif.pred_valid); end
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL bp_accept_state got=%0d exp=%0d", dbg_state, IDLE); end
  endtask

  task automatic test_overrun();
    int lat, bcnt;
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_before got=%b exp=0", overrun); end
    set_all(16'h0010);
    sc[2] = 16'h0500;
    apply_scores();
    start_capture();
    for (int k = 0; k < 4; k++) cyc();
    sc[8] = 16'hFFFF;
    apply_scores();
    done_in = 1'b1;
    cyc();
    done_in = 1'b0;
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", overrun); end
    wait_valid(lat, bcnt);
    checks++; if (pif.pred_digit !== 4'd2) begin failures++; $display("FAIL ovr_digit got=%0d exp=2", pif.pred_digit); end
    checks++; if (pif.pred_score !== 16'h0500) begin failures++; $display("FAIL ovr_score got=%h exp=0500", pif.pred_score); end
    handshake();
    cyc(); cyc();
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL ovr_no_restart got=%0d exp=%0d", dbg_state, IDLE); end
  endtask

  task automatic test_reset_mid_scan();
    int lat, bcnt;
    set_all(16'h0020);
    start_capture();
    for (int k = 0; k < 5; k++) cyc();
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_async_busy got=%b exp=0", busy); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rst_async_overrun got=%b exp=0", overrun); end
    cyc();
    rst = 1'b0;
    cyc(); cyc(); cyc();
    checks++; if (pif.pred_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", pif.pred_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rst_mid_overrun got=%b exp=0", overrun); end
    sc[4] = 16'h0777;
    apply_scores();
    start_capture();
    wait_valid(lat, bcnt);
    checks++; if (lat !== 10) begin failures++; $display("FAIL rst_fresh_latency got=%0d exp=10", lat); end
    checks++; if (pif.pred_digit !== 4'd4) begin failures++; $display("FAIL rst_fresh_digit got=%0d exp=4", pif.pred_digit); end
    checks++; if (pif.pred_score !== 16'h0777) begin failures++; $display("FAIL rst_fresh_score got=%h exp=0777", pif.pred_score); end
    handshake();
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    set_all(16'h0001);
    sc[0] = 16'h0F00;
    apply_scores();
    pif.pred_ready = 1'b1;
    start_capture();
    wait_valid(lat, bcnt);
    checks++; if (pif.pred_digit !== 4'd0) begin failures++; $display("FAIL b2b_first_digit got=%0d exp=0", pif.pred_digit); end
    cyc();                         // handshake edge (ready held high)
    set_all(16'h0002);
    sc[6] = 16'h0300;
    apply_scores();
    start_capture();               // earliest next capture: 12 cycles after the first
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_recapture got=%b exp=1", busy); end
    wait_valid(lat, bcnt);
    checks++; if (lat !== 10) begin failures++; $display("FAIL b2b_latency got=%0d exp=10", lat); end
    checks++; if (pif.pred_digit !== 4'd6) begin failures++; $display("FAIL b2b_second_digit got=%0d exp=6", pif.pred_digit); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
    // A rising edge on the handshake edge itself is dropped.
    done_in = 1'b1;
    cyc();
    done_in = 1'b0;
    pif.pred_ready = 1'b0;
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL hs_edge_overrun got=%b exp=1", overrun); end
    checks++; if (pif.pred_valid !== 1'b0) begin failures++; $display("FAIL hs_edge_valid got=%b exp=0", pif.pred_valid); end
    cyc(); cyc();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hs_edge_dropped got=%b exp=0", busy); end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_msb();
    test_backpressure();
    test_overrun();
    test_reset_mid_scan();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
